// File: rtl/clk_monitor.sv
// Frequency monitor for an asynchronous clock: counts clkin rising edges over a
// fixed window of system-clock cycles and flags a clkin that has stopped toggling.
module clk_monitor #(
    parameter int WINDOW  = 1000,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64,
    parameter int MIN_CNT = 0,
    parameter int MAX_CNT = 65535
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clkin,
    output logic [CNT_W-1:0] edge_count,
    output logic             count_valid,
    output logic             in_range,
    output logic             stuck,
    output logic             busy
);

    localparam int WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam int STK_W = $clog2(TIMEOUT + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(TIMEOUT);
    localparam logic [31:0]      MIN_L    = 32'(MIN_CNT);
    localparam logic [31:0]      MAX_L    = 32'(MAX_CNT);

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        REPORT
    } state_t;

    state_t state;
    state_t state_next;

    logic             sync1;
    logic             sync2;
    logic             hist;
    logic             edge_flag;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] edge_total;
    logic [STK_W-1:0] stuck_cnt;
    logic [31:0]      total_ext;
    logic             above_min;
    logic             below_max;

    // The count including this cycle's flag is what gets reported on the last window cycle.
    assign edge_total = (edge_flag && (edge_cnt != {CNT_W{1'b1}})) ? edge_cnt + CNT_W'(1) : edge_cnt;
    assign total_ext  = 32'(edge_total);
    assign below_max  = (total_ext <= MAX_L);

    if (MIN_CNT == 0) begin : g_no_min
        assign above_min = 1'b1;
    end else begin : g_min
        assign above_min = (total_ext >= MIN_L);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable) state_next = MEASURE;
            end
            MEASURE: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (win_cnt == WIN_LAST) begin
                    state_next = REPORT;
                end
            end
            REPORT: begin
                state_next = enable ? MEASURE : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            hist      <= 1'b0;
            edge_flag <= 1'b0;
        end else begin
            sync1     <= clkin;
            sync2     <= sync1;
            hist      <= sync2;
            edge_flag <= sync2 & ~hist;
        end
    end

    // Counters sit at zero outside MEASURE so every window starts clean.
    always_ff @(posedge clock) begin
        if (!reset) begin
            win_cnt  <= '0;
            edge_cnt <= '0;
        end else if (state == MEASURE) begin
            win_cnt  <= win_cnt + WIN_W'(1);
            edge_cnt <= edge_total;
        end else begin
            win_cnt  <= '0;
            edge_cnt <= '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            edge_count  <= '0;
            in_range    <= 1'b0;
            count_valid <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            if ((state == MEASURE) && (state_next == REPORT)) begin
                edge_count  <= edge_total;
                in_range    <= above_min & below_max;
                count_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            stuck_cnt <= '0;
        end else if (edge_flag) begin
            stuck_cnt <= '0;
        end else if (stuck_cnt != STK_MAX) begin
            stuck_cnt <= stuck_cnt + STK_W'(1);
        end
    end

    assign stuck = (stuck_cnt == STK_MAX);
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_clk_monitor.sv
// Randomised bench for clk_monitor: two instances (16-bit and saturating 4-bit
// counters) checked every cycle against a window-sum reference model.
module tb_clk_monitor;

    localparam int WINDOW = 100;
    localparam int TO1    = 64;
    localparam int TO2    = 5;
    localparam int DEPTH  = 8192;

    logic        clock  = 1'b0;
    logic        reset  = 1'b0;
    logic        enable = 1'b0;
    logic        clkin  = 1'b0;
    logic [15:0] ec1;
    logic        cv1, ir1, st1, bz1;
    logic [3:0]  ec2;
    logic        cv2, ir2, st2, bz2;

    int total = 0;
    int bad   = 0;

    // Reference model: sampled clkin history, derived edge flags, window bookkeeping.
    bit samp   [DEPTH];
    bit flagAt [DEPTH];
    int cyc        = -1;
    int resetEdge  = 0;
    int lastClear  = 0;
    int winStart   = 0;
    bit running    = 1'b0;
    bit reporting  = 1'b0;
    int expEc1     = 0;
    int expEc2     = 0;
    bit expIr1     = 1'b0;
    bit expIr2     = 1'b0;
    bit expCv      = 1'b0;
    bit expBusy    = 1'b0;

    int halfPer    = 0;
    int phaseCnt   = 0;
    bit randomMode = 1'b0;

    always #5 clock = ~clock;

    clk_monitor #(
        .WINDOW(WINDOW), .CNT_W(16), .TIMEOUT(TO1), .MIN_CNT(24), .MAX_CNT(26)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .clkin(clkin),
        .edge_count(ec1), .count_valid(cv1), .in_range(ir1), .stuck(st1), .busy(bz1)
    );

    clk_monitor #(
        .WINDOW(WINDOW), .CNT_W(4), .TIMEOUT(TO2), .MIN_CNT(1), .MAX_CNT(10)
    ) dutNarrow (
        .clock(clock), .reset(reset), .enable(enable), .clkin(clkin),
        .edge_count(ec2), .count_valid(cv2), .in_range(ir2), .stuck(st2), .busy(bz2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    // A window's result is the saturated number of edge flags seen during its cycles.
    task automatic modelEdge(input bit r, input bit e, input bit c);
        int sum;
        cyc++;
        if (!r) begin
            samp[cyc] = 1'b0;
            resetEdge = cyc;
            lastClear = cyc;
            running   = 1'b0;
            reporting = 1'b0;
            expEc1    = 0;
            expEc2    = 0;
            expIr1    = 1'b0;
            expIr2    = 1'b0;
            expCv     = 1'b0;
        end else begin
            samp[cyc] = c;
            expCv     = 1'b0;
            if (flagAt[cyc-1]) lastClear = cyc;
            if (reporting) begin
                reporting = 1'b0;
                if (e) begin
                    running  = 1'b1;
                    winStart = cyc;
                end
            end else if (running) begin
                if (!e) begin
                    running = 1'b0;
                end else if (cyc - winStart == WINDOW) begin
                    sum = 0;
                    for (int i = winStart; i < cyc; i++) sum += int'(flagAt[i]);
                    running   = 1'b0;
                    reporting = 1'b1;
                    expCv     = 1'b1;
                    expEc1    = (sum > 65535) ? 65535 : sum;
                    expEc2    = (sum > 15) ? 15 : sum;
                    expIr1    = (expEc1 >= 24) && (expEc1 <= 26);
                    expIr2    = (expEc2 >= 1) && (expEc2 <= 10);
                end
            end else if (e) begin
                running  = 1'b1;
                winStart = cyc;
            end
        end
        flagAt[cyc] = (cyc - resetEdge >= 3) && samp[cyc-2] && !samp[cyc-3];
        expBusy     = running || reporting;
    endtask

    task automatic checkAll();
        checkOutput("edgeCount16", 32'(ec1), 32'(expEc1));
        checkOutput("countValid16", 32'(cv1), 32'(expCv));
        checkOutput("inRange16", 32'(ir1), 32'(expIr1));
        checkOutput("stuck64", 32'(st1), 32'((cyc - lastClear) >= TO1));
        checkOutput("busy16", 32'(bz1), 32'(expBusy));
        checkOutput("edgeCount4", 32'(ec2), 32'(expEc2));
        checkOutput("countValid4", 32'(cv2), 32'(expCv));
        checkOutput("inRange4", 32'(ir2), 32'(expIr2));
        checkOutput("stuck5", 32'(st2), 32'((cyc - lastClear) >= TO2));
        checkOutput("busy4", 32'(bz2), 32'(expBusy));
    endtask

    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            modelEdge(reset, enable, clkin);
            #1;
            checkAll();
            if (halfPer > 0) begin
                phaseCnt++;
                if (phaseCnt >= halfPer) begin
                    clkin    = ~clkin;
                    phaseCnt = 0;
                    if (randomMode) halfPer = $urandom_range(2, 6);
                end
            end
        end
    endtask

    initial begin
        int guard;

        $display("[TB] reset with clkin idle");
        applyStimulus(4);
        reset = 1'b1;
        applyStimulus(3);

        $display("[TB] clkin period 4, continuous windows");
        halfPer = 2;
        enable  = 1'b1;
        applyStimulus(3 * (WINDOW + 1) + 5);

        $display("[TB] clkin period 8");
        halfPer = 4;
        applyStimulus(2 * (WINDOW + 1) + 10);

        $display("[TB] enable dropped mid-window");
        guard = 0;
        while (!(running && (cyc - winStart == 50)) && guard < 300) begin
            applyStimulus(1);
            guard++;
        end
        checkOutput("midWindowReached", 32'(guard < 300), 32'd1);
        enable = 1'b0;
        applyStimulus(6);

        $display("[TB] clkin stopped, then one rise");
        halfPer = 0;
        clkin   = 1'b0;
        enable  = 1'b1;
        applyStimulus(2 * (WINDOW + 1) + 20);
        clkin = 1'b1;
        applyStimulus(6);
        clkin = 1'b0;
        applyStimulus(3);

        $display("[TB] random clkin and enable");
        randomMode = 1'b1;
        halfPer    = $urandom_range(2, 6);
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            applyStimulus(1);
        end

        $display("[TB] reset pulse mid-measure");
        randomMode = 1'b0;
        halfPer    = 2;
        enable     = 1'b1;
        applyStimulus(40);
        reset = 1'b0;
        applyStimulus(1);
        reset = 1'b1;
        applyStimulus(2 * (WINDOW + 1) + 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
